// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-programmable pattern of 1..PAT_W bits.
// Supports overlap/non-overlap matching, Mealy/Moore match timing and a saturating match counter.
module seq_pattern_detector #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cfg_mealy,
    input  logic                         clr,
    input  logic                         din_valid,
    input  logic                         din,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat,
    output logic                         armed
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [PAT_W-2:0] hist, hist_n;
    logic [LEN_W-1:0] fill, fill_n;
    logic [PAT_W-1:0] pat_r, pat_n;
    logic [LEN_W-1:0] len_r, len_n;
    logic             overlap_r, overlap_n;
    logic             mealy_r, mealy_n;
    logic             moore_r, moore_n;
    logic             armed_n;
    logic [CNT_W-1:0] cnt_n;
    logic             sat_n;

    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] len_m1;
    logic [LEN_W-1:0] load_len;
    logic             accept;
    logic             eligible;
    logic             hit;

    // Zero means a one-bit pattern; anything past PAT_W is clamped to the full width.
    function automatic logic [LEN_W-1:0] clip_len(input logic [LEN_W-1:0] l);
        if (l == '0)
            return LEN_W'(1);
        else if (l > LEN_W'(PAT_W))
            return LEN_W'(PAT_W);
        else
            return l;
    endfunction

    assign load_len = clip_len(cfg_len);
    assign len_m1   = len_r - LEN_W'(1);
    assign cand     = {hist, din};

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len_r));
        end
    end

    // A bit arriving alongside cfg_load or clr is dropped, never shifted or matched.
    assign accept   = din_valid & ~cfg_load & ~clr & (state != IDLE);
    assign eligible = (state == HUNT) | ((state == FILL) & (fill == len_m1));
    assign hit      = accept & eligible & ((cand & mask) == (pat_r & mask));
    assign match    = mealy_r ? hit : moore_r;

    always_comb begin
        state_n   = state;
        hist_n    = hist;
        fill_n    = fill;
        pat_n     = pat_r;
        len_n     = len_r;
        overlap_n = overlap_r;
        mealy_n   = mealy_r;
        armed_n   = armed;
        cnt_n     = match_cnt;
        sat_n     = cnt_sat;
        moore_n   = hit;

        if (cfg_load) begin
            pat_n     = cfg_pattern;
            len_n     = load_len;
            overlap_n = cfg_overlap;
            mealy_n   = cfg_mealy;
            armed_n   = 1'b1;
            hist_n    = '0;
            fill_n    = '0;
            cnt_n     = '0;
            sat_n     = 1'b0;
            moore_n   = 1'b0;
            state_n   = (load_len == LEN_W'(1)) ? HUNT : FILL;
        end else if (clr) begin
            hist_n  = '0;
            fill_n  = '0;
            cnt_n   = '0;
            sat_n   = 1'b0;
            moore_n = 1'b0;
            if (armed)
                state_n = (len_r == LEN_W'(1)) ? HUNT : FILL;
            else
                state_n = IDLE;
        end else if (accept) begin
            if (hit && (match_cnt != '1)) begin
                cnt_n = match_cnt + CNT_W'(1);
                if (cnt_n == '1)
                    sat_n = 1'b1;
            end
            if (hit && !overlap_r) begin
                hist_n  = '0;
                fill_n  = '0;
                state_n = (len_r == LEN_W'(1)) ? HUNT : FILL;
            end else begin
                hist_n = cand[PAT_W-2:0];
                if (state == FILL) begin
                    if (fill != len_m1)
                        fill_n = fill + LEN_W'(1);
                    if (fill_n == len_m1)
                        state_n = HUNT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hist      <= '0;
            fill      <= '0;
            pat_r     <= '0;
            len_r     <= '0;
            overlap_r <= 1'b0;
            mealy_r   <= 1'b0;
            moore_r   <= 1'b0;
            armed     <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            fill      <= fill_n;
            pat_r     <= pat_n;
            len_r     <= len_n;
            overlap_r <= overlap_n;
            mealy_r   <= mealy_n;
            moore_r   <= moore_n;
            armed     <= armed_n;
            match_cnt <= cnt_n;
            cnt_sat   <= sat_n;
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: expected match bits are queued as each bit is driven
// and popped when the DUT output for that bit is due; a CNT_W=2 instance covers saturation.
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cfg_mealy;
    logic       clr;
    logic       din_valid;
    logic       din;

    logic       match;
    logic [7:0] match_cnt;
    logic       cnt_sat;
    logic       armed;

    logic       match_c2;
    logic [1:0] cnt_c2;
    logic       sat_c2;
    logic       armed_c2;

    logic       exp_q[$];
    logic       mealy_mode;
    int         n_checks = 0;
    int         n_pass   = 0;

    seq_pattern_detector #(.PAT_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_mealy(cfg_mealy), .clr(clr),
        .din_valid(din_valid), .din(din), .match(match), .match_cnt(match_cnt),
        .cnt_sat(cnt_sat), .armed(armed)
    );

    seq_pattern_detector #(.PAT_W(8), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_mealy(cfg_mealy), .clr(clr),
        .din_valid(din_valid), .din(din), .match(match_c2), .match_cnt(cnt_c2),
        .cnt_sat(sat_c2), .armed(armed_c2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_match(input string tag);
        logic e;
        e = exp_q.pop_front();
        check(tag, 32'(match), 32'(e));
    endtask

    // Entered at posedge+1. Mealy output is sampled before the next edge, Moore just after it.
    task automatic step(input logic v, input logic b, input logic exp_hit, input string tag);
        din_valid = v;
        din       = b;
        exp_q.push_back(exp_hit);
        if (mealy_mode) begin
            #3;
            check_match(tag);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            check_match(tag);
        end
        din_valid = 1'b0;
    endtask

    // Bits and expected hits are given first-bit-at-MSB of an n-bit field.
    task automatic run_bits(input int n, input logic [15:0] bits, input logic [15:0] exp, input string tag);
        for (int k = 0; k < n; k++) begin
            step(1'b1, bits[n-1-k], exp[n-1-k], tag);
        end
    endtask

    // The concurrent valid din=1 must be dropped; cfg_* are scrambled afterwards and must be ignored.
    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov, input logic me);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_mealy   = me;
        cfg_load    = 1'b1;
        din_valid   = 1'b1;
        din         = 1'b1;
        @(posedge clk); #1;
        cfg_load    = 1'b0;
        din_valid   = 1'b0;
        cfg_pattern = 8'($urandom);
        cfg_len     = 4'($urandom);
        cfg_overlap = 1'($urandom);
        cfg_mealy   = 1'($urandom);
        mealy_mode  = me;
        check("load_cnt", 32'(match_cnt), 0);
        check("load_armed", 32'(armed), 1);
    endtask

    initial begin
        rst_n = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_mealy = 1'b0; clr = 1'b0; din_valid = 1'b0; din = 1'b0; mealy_mode = 1'b1;
        #1;
        check("rst_match", 32'(match), 0);
        check("rst_cnt", 32'(match_cnt), 0);
        check("rst_sat", 32'(cnt_sat), 0);
        check("rst_armed", 32'(armed), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unconfigured: bits are ignored
        run_bits(4, 16'b1011, 16'b0000, "idle_match");
        check("idle_armed", 32'(armed), 0);

        // Overlapping Mealy 1011
        load(8'b1011, 4'd4, 1'b1, 1'b1);
        run_bits(7, 16'b1011011, 16'b0001001, "t1_match");
        check("t1_cnt", 32'(match_cnt), 2);

        // Non-overlapping: second embedded 1011 must not fire
        load(8'b1011, 4'd4, 1'b0, 1'b1);
        run_bits(8, 16'b10110111, 16'b00010000, "t2_match");
        check("t2_cnt", 32'(match_cnt), 1);

        // Moore 110: output one cycle late and one cycle wide
        load(8'b110, 4'd3, 1'b1, 1'b0);
        run_bits(3, 16'b110, 16'b001, "t3_match");
        step(1'b0, 1'b0, 1'b0, "t3_width");
        check("t3_cnt", 32'(match_cnt), 1);

        // len=1 pattern 1; saturation on the 2-bit counter instance
        load(8'h01, 4'd1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, "t4_match");
            check("t4_cnt_c2", 32'(cnt_c2), (i + 1 < 3) ? i + 1 : 3);
            check("t4_sat_c2", 32'(sat_c2), (i >= 2) ? 1 : 0);
        end
        check("t4_cnt", 32'(match_cnt), 5);
        check("t4_sat", 32'(cnt_sat), 0);
        clr = 1'b1;
        step(1'b1, 1'b1, 1'b0, "t4_clr_drop");
        clr = 1'b0;
        check("t4_clr_cnt_c2", 32'(cnt_c2), 0);
        check("t4_clr_sat_c2", 32'(sat_c2), 0);
        check("t4_clr_armed", 32'(armed_c2), 1);
        check("t4_clr_cnt", 32'(match_cnt), 0);
        step(1'b1, 1'b1, 1'b1, "t4_after_clr");
        check("t4_after_cnt", 32'(cnt_c2), 1);

        // din_valid gaps inside a 1011 stream
        load(8'b1011, 4'd4, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, "t5_gap");
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, "t5_gap");
        step(1'b1, 1'b0, 1'b0, "t5_gap");
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, "t5_gap");
        step(1'b1, 1'b1, 1'b0, "t5_gap");
        step(1'b1, 1'b1, 1'b1, "t5_gap");
        check("t5_cnt", 32'(match_cnt), 1);
        run_bits(2, 16'b10, 16'b00, "t5_partial");
        // len=0 reload mid-stream: one-bit pattern, history and count cleared
        load(8'h01, 4'd0, 1'b1, 1'b1);
        run_bits(3, 16'b101, 16'b101, "t5_len0");
        check("t5_len0_cnt", 32'(match_cnt), 2);

        // Oversized length clamps to the full 8-bit pattern
        load(8'hA5, 4'd15, 1'b1, 1'b1);
        run_bits(8, 16'hA5, 16'h01, "clip_match");
        check("clip_cnt", 32'(match_cnt), 1);

        // Async reset while filling after a non-overlap hit
        load(8'b1011, 4'd4, 1'b0, 1'b1);
        run_bits(6, 16'b101110, 16'b000100, "t6_pre");
        check("t6_pre_cnt", 32'(match_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_armed", 32'(armed), 0);
        check("t6_rst_cnt", 32'(match_cnt), 0);
        check("t6_rst_match", 32'(match), 0);
        check("t6_rst_sat_c2", 32'(sat_c2), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mealy_mode = 1'b1;
        run_bits(4, 16'b1011, 16'b0000, "t6_ignored");
        check("t6_ignored_cnt", 32'(match_cnt), 0);
        check("t6_ignored_armed", 32'(armed), 0);
        load(8'b1011, 4'd4, 1'b1, 1'b1);
        run_bits(4, 16'b1011, 16'b0001, "t6_rearm");
        check("t6_rearm_cnt", 32'(match_cnt), 1);

        check("queue_drain", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
